// File: rtl/main_memory_arbiter_pkg.sv
// Purpose: shared encodings for the main-memory arbiter (FSM states, port IDs, timeout default).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package main_memory_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_e;

    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int DEFAULT_TIMEOUT_CYCLES = 15;
    localparam int CNT_W                  = 8;

    // Round-robin choice: a lone requester wins outright; on a tie the port
    // that was not granted last time wins.
    function automatic logic pick_port(input logic f_pend, input logic d_pend,
                                       input logic last_grant);
        if (f_pend && d_pend) begin
            return ~last_grant;
        end
        if (d_pend) begin
            return PORT_D;
        end
        return PORT_F;
    endfunction

endpackage

// File: rtl/main_memory_arbiter_mem_req_slot.sv
// Purpose: one-deep request slot; holds a pending bit plus the address/wr/wdata captured with the request pulse.
// Latency: request visible on pend_out one edge after req_in.
// Backpressure: a request arriving while the slot is full (and not being cleared) is dropped.
// Ports: clk/rst; req_in + wr_in/addr_in/wdata_in capture; clr_in frees the slot;
//        pend_out/wr_out/addr_out/wdata_out present the held request.
module main_memory_arbiter_mem_req_slot
    import main_memory_arbiter_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_in,
    input  logic          wr_in,
    input  logic [DW-1:0] addr_in,
    input  logic [DW-1:0] wdata_in,
    input  logic          clr_in,
    output logic          pend_out,
    output logic          wr_out,
    output logic [DW-1:0] addr_out,
    output logic [DW-1:0] wdata_out
);

    logic          pend_q, pend_d;
    logic          wr_q, wr_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    // A new request is accepted into an empty slot, or into the slot that is
    // being freed this very cycle (set wins over clear).
    always_comb begin
        pend_d  = pend_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (req_in && (!pend_q || clr_in)) begin
            pend_d  = 1'b1;
            wr_d    = wr_in;
            addr_d  = addr_in;
            wdata_d = wdata_in;
        end else if (clr_in) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q  <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            pend_q  <= pend_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign pend_out  = pend_q;
    assign wr_out    = wr_q;
    assign addr_out  = addr_q;
    assign wdata_out = wdata_q;

endmodule

// File: rtl/main_memory_arbiter.sv
// Purpose: shares MAIN_MEMORY between fetch (F, read-only) and data (D) ports, round-robin, one transaction at a time.
// Latency: request edge -> ACCESS after +1 edge -> Ack pulse after +2 edges with a zero-wait memory; memory waits bounded by TIMEOUT_CYCLES.
// Backpressure: none toward requesters; each port has a one-deep slot and a repeat request while pending is dropped.
// Ports: CLOCK_50/ResetInHigh_In; F/D request pulses with address (D adds wr/wdata); F/D Ack pulses with
//        shared RData/Err; Mem A/B/RD/WR strobes out and MemACK/MemData back from the memory.
module main_memory_arbiter
    import main_memory_arbiter_pkg::*;
#(
    parameter int DATAWIDTH_BUS  = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                     MAIN_MEMORY_ARBITER_CLOCK_50,
    input  logic                     MAIN_MEMORY_ARBITER_ResetInHigh_In,
    input  logic                     MAIN_MEMORY_ARBITER_FReq_In,
    input  logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_ARBITER_FAddr_InBus,
    output logic                     MAIN_MEMORY_ARBITER_FAck_Out,
    input  logic                     MAIN_MEMORY_ARBITER_DReq_In,
    input  logic                     MAIN_MEMORY_ARBITER_DWr_In,
    input  logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_ARBITER_DAddr_InBus,
    input  logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_ARBITER_DWData_InBus,
    output logic                     MAIN_MEMORY_ARBITER_DAck_Out,
    output logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_ARBITER_RData_OutBus,
    output logic                     MAIN_MEMORY_ARBITER_Err_Out,
    output logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_ARBITER_MemA_OutBus,
    output logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_ARBITER_MemB_OutBus,
    output logic                     MAIN_MEMORY_ARBITER_MemRD_Out,
    output logic                     MAIN_MEMORY_ARBITER_MemWR_Out,
    input  logic                     MAIN_MEMORY_ARBITER_MemACK_In,
    input  logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_ARBITER_MemData_InBus
);

    localparam int DW = DATAWIDTH_BUS;
    // Counter value on the last ACCESS cycle we are willing to wait through.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic clk, rst;
    assign clk = MAIN_MEMORY_ARBITER_CLOCK_50;
    assign rst = MAIN_MEMORY_ARBITER_ResetInHigh_In;

    logic          f_pend, f_wr, f_clr;
    logic          d_pend, d_wr, d_clr;
    logic [DW-1:0] f_addr, f_wdata, d_addr, d_wdata;

    arb_state_e       state_q, state_d;
    logic             grant_q, grant_d;    // last granted port == port in flight
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             f_ack_q, f_ack_d, d_ack_q, d_ack_d, err_q, err_d;
    logic             mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
    logic [DW-1:0]    rdata_q, rdata_d, mem_a_q, mem_a_d, mem_b_q, mem_b_d;

    logic          sel_wr;
    logic [DW-1:0] sel_addr, sel_wdata;

    main_memory_arbiter_mem_req_slot #(.DW(DW)) u_f_slot (
        .clk       (clk),
        .rst       (rst),
        .req_in    (MAIN_MEMORY_ARBITER_FReq_In),
        .wr_in     (1'b0),
        .addr_in   (MAIN_MEMORY_ARBITER_FAddr_InBus),
        .wdata_in  ('0),
        .clr_in    (f_clr),
        .pend_out  (f_pend),
        .wr_out    (f_wr),
        .addr_out  (f_addr),
        .wdata_out (f_wdata)
    );

    main_memory_arbiter_mem_req_slot #(.DW(DW)) u_d_slot (
        .clk       (clk),
        .rst       (rst),
        .req_in    (MAIN_MEMORY_ARBITER_DReq_In),
        .wr_in     (MAIN_MEMORY_ARBITER_DWr_In),
        .addr_in   (MAIN_MEMORY_ARBITER_DAddr_InBus),
        .wdata_in  (MAIN_MEMORY_ARBITER_DWData_InBus),
        .clr_in    (d_clr),
        .pend_out  (d_pend),
        .wr_out    (d_wr),
        .addr_out  (d_addr),
        .wdata_out (d_wdata)
    );

    // The slot is freed on the Ack cycle; a fresh request on that same edge is kept.
    assign f_clr = (state_q == ST_DONE) && (grant_q == PORT_F);
    assign d_clr = (state_q == ST_DONE) && (grant_q == PORT_D);

    // Slot contents stay frozen while pending, so the request being served can be read live.
    assign sel_wr    = (grant_d == PORT_D) ? d_wr    : f_wr;
    assign sel_addr  = (grant_d == PORT_D) ? d_addr  : f_addr;
    assign sel_wdata = (grant_d == PORT_D) ? d_wdata : f_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= PORT_D;
            cnt_q    <= '0;
            f_ack_q  <= 1'b0;
            d_ack_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            mem_a_q  <= '0;
            mem_b_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            f_ack_q  <= f_ack_d;
            d_ack_q  <= d_ack_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            mem_rd_q <= mem_rd_d;
            mem_wr_q <= mem_wr_d;
            mem_a_q  <= mem_a_d;
            mem_b_q  <= mem_b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (f_pend || d_pend) begin
                    grant_d = pick_port(f_pend, d_pend, grant_q);
                    cnt_d   = '0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (MAIN_MEMORY_ARBITER_MemACK_In || (cnt_q == TIMEOUT_LAST)) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered: decoded from the state being entered.
    always_comb begin
        f_ack_d  = 1'b0;
        d_ack_d  = 1'b0;
        err_d    = 1'b0;
        rdata_d  = '0;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        mem_a_d  = '0;
        mem_b_d  = '0;
        if (state_d == ST_ACCESS) begin
            mem_rd_d = ~sel_wr;
            mem_wr_d = sel_wr;
            mem_a_d  = sel_addr;
            mem_b_d  = sel_wr ? sel_wdata : '0;
        end
        if ((state_q == ST_ACCESS) && (state_d == ST_DONE)) begin
            f_ack_d = (grant_q == PORT_F);
            d_ack_d = (grant_q == PORT_D);
            err_d   = ~MAIN_MEMORY_ARBITER_MemACK_In;
            rdata_d = (MAIN_MEMORY_ARBITER_MemACK_In && !sel_wr)
                      ? MAIN_MEMORY_ARBITER_MemData_InBus : '0;
        end
    end

    assign MAIN_MEMORY_ARBITER_FAck_Out     = f_ack_q;
    assign MAIN_MEMORY_ARBITER_DAck_Out     = d_ack_q;
    assign MAIN_MEMORY_ARBITER_RData_OutBus = rdata_q;
    assign MAIN_MEMORY_ARBITER_Err_Out      = err_q;
    assign MAIN_MEMORY_ARBITER_MemA_OutBus  = mem_a_q;
    assign MAIN_MEMORY_ARBITER_MemB_OutBus  = mem_b_q;
    assign MAIN_MEMORY_ARBITER_MemRD_Out    = mem_rd_q;
    assign MAIN_MEMORY_ARBITER_MemWR_Out    = mem_wr_q;

endmodule

// File: tb/tb_main_memory_arbiter.sv
// Purpose: self-checking bench for main_memory_arbiter: directed scenarios plus a randomized run against a transaction model.
// Latency: n/a.
// Backpressure: n/a.
module tb_main_memory_arbiter;

    localparam int TO = 15;

    logic        clk, rst;
    logic        f_req, f_ack, d_req, d_wr, d_ack, err;
    logic [31:0] f_addr, d_addr, d_wdata, rdata;
    logic [31:0] mem_a, mem_b, mem_data;
    logic        mem_rd, mem_wr, mem_ack;

    int checks = 0;
    int errors = 0;

    main_memory_arbiter dut (
        .MAIN_MEMORY_ARBITER_CLOCK_50       (clk),
        .MAIN_MEMORY_ARBITER_ResetInHigh_In (rst),
        .MAIN_MEMORY_ARBITER_FReq_In        (f_req),
        .MAIN_MEMORY_ARBITER_FAddr_InBus    (f_addr),
        .MAIN_MEMORY_ARBITER_FAck_Out       (f_ack),
        .MAIN_MEMORY_ARBITER_DReq_In        (d_req),
        .MAIN_MEMORY_ARBITER_DWr_In         (d_wr),
        .MAIN_MEMORY_ARBITER_DAddr_InBus    (d_addr),
        .MAIN_MEMORY_ARBITER_DWData_InBus   (d_wdata),
        .MAIN_MEMORY_ARBITER_DAck_Out       (d_ack),
        .MAIN_MEMORY_ARBITER_RData_OutBus   (rdata),
        .MAIN_MEMORY_ARBITER_Err_Out        (err),
        .MAIN_MEMORY_ARBITER_MemA_OutBus    (mem_a),
        .MAIN_MEMORY_ARBITER_MemB_OutBus    (mem_b),
        .MAIN_MEMORY_ARBITER_MemRD_Out      (mem_rd),
        .MAIN_MEMORY_ARBITER_MemWR_Out      (mem_wr),
        .MAIN_MEMORY_ARBITER_MemACK_In      (mem_ack),
        .MAIN_MEMORY_ARBITER_MemData_InBus  (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 2) return 32'h8680_4002;
        return {8'hC3, i[7:0], ~i[7:0], 8'h5A};
    endfunction

    // ---------------- memory responder ----------------
    // Acks once it has seen a strobe for mem_lat cycles; mem_lat is chosen per transaction.
    logic [31:0] mem [256];
    int acc_cnt;
    int mem_lat;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt <= 0;
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (mem_rd || mem_wr) begin
            acc_cnt <= acc_cnt + 1;
            if (mem_wr && mem_ack) mem[mem_a[7:0]] <= mem_b;
        end else begin
            acc_cnt <= 0;
        end
    end

    assign mem_ack  = (mem_rd || mem_wr) && (acc_cnt == mem_lat);
    assign mem_data = mem_rd ? mem[mem_a[7:0]] : 32'h0BAD_0BAD;

    // ---------------- transaction-level reference model ----------------
    // Slots, round-robin choice and the timeline of a transaction
    // (select edge, ack edge = select + waited cycles + 1, free on the next edge).
    int          fixed_lat;   // <0: random latency per transaction
    int          n;
    bit          m_pend [2];
    logic [31:0] m_addr [2];
    bit          m_dwr;
    logic [31:0] m_dwdata;
    bit          m_busy;
    int          m_port, m_last, m_ack_edge;
    bit          t_wr, t_err;
    logic [31:0] t_addr, t_wdata, t_rdata;
    logic [31:0] sh [256];
    logic        e_fack, e_dack, e_rd, e_wr, e_err;
    logic [31:0] e_a, e_b, e_rdata;

    always @(posedge clk or posedge rst) begin : model
        bit clr, req, in_acc, ack;
        int lat;
        if (rst) begin
            n = 0; m_busy = 0; m_last = 1; mem_lat = 0;
            m_pend[0] = 0; m_pend[1] = 0;
            for (int i = 0; i < 256; i++) sh[i] = init_word(i);
            e_fack = 0; e_dack = 0; e_rd = 0; e_wr = 0; e_err = 0;
            e_a = 0; e_b = 0; e_rdata = 0;
        end else begin
            n++;
            if (!m_busy && (m_pend[0] || m_pend[1])) begin
                if (m_pend[0] && m_pend[1]) m_port = 1 - m_last;
                else                        m_port = m_pend[1] ? 1 : 0;
                m_last = m_port;
                m_busy = 1;
                if (fixed_lat >= 0)                  lat = fixed_lat;
                else if ($urandom_range(0, 7) == 0)  lat = 14 + $urandom_range(0, 30);
                else                                 lat = $urandom_range(0, 4);
                mem_lat    = lat;
                t_err      = (lat >= TO);
                m_ack_edge = n + (t_err ? TO - 1 : lat) + 1;
                t_wr       = (m_port == 1) && m_dwr;
                t_addr     = m_addr[m_port];
                t_wdata    = t_wr ? m_dwdata : 32'h0;
                t_rdata    = (t_err || t_wr) ? 32'h0 : sh[t_addr[7:0]];
                if (t_wr && !t_err) sh[t_addr[7:0]] = m_dwdata;
            end
            for (int p = 0; p < 2; p++) begin
                clr = m_busy && (m_port == p) && (n == m_ack_edge + 1);
                req = (p == 0) ? f_req : d_req;
                if (req && (!m_pend[p] || clr)) begin
                    m_pend[p] = 1;
                    m_addr[p] = (p == 0) ? f_addr : d_addr;
                    if (p == 1) begin
                        m_dwr    = d_wr;
                        m_dwdata = d_wdata;
                    end
                end else if (clr) begin
                    m_pend[p] = 0;
                end
                if (clr) m_busy = 0;
            end
            in_acc  = m_busy && (n < m_ack_edge);
            ack     = m_busy && (n == m_ack_edge);
            e_rd    = in_acc && !t_wr;
            e_wr    = in_acc && t_wr;
            e_a     = in_acc ? t_addr : 32'h0;
            e_b     = in_acc ? t_wdata : 32'h0;
            e_fack  = ack && (m_port == 0);
            e_dack  = ack && (m_port == 1);
            e_rdata = ack ? t_rdata : 32'h0;
            e_err   = ack && t_err;
        end
    end

    task automatic apply_reset();
        rst = 1'b1;
        f_req = 0; d_req = 0; d_wr = 0; f_addr = 0; d_addr = 0; d_wdata = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({f_ack, d_ack, mem_rd, mem_wr, err} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b want 00000", {f_ack, d_ack, mem_rd, mem_wr, err});
        end
        checks++;
        if ({mem_a, mem_b, rdata} !== 96'h0) begin
            errors++; $display("FAIL reset_buses got a=%h b=%h r=%h want 0", mem_a, mem_b, rdata);
        end
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_rd, mem_wr, f_ack, d_ack} !== 4'b0) begin
            errors++; $display("FAIL reset_idle got %b want 0000", {mem_rd, mem_wr, f_ack, d_ack});
        end
    endtask

    task automatic test_fetch();
        apply_reset(); fixed_lat = 0;
        @(negedge clk); f_req = 1; f_addr = 32'd2;
        @(negedge clk); f_req = 0; f_addr = 32'hFFFF_FFFF;
        checks++;
        if (mem_rd !== 1'b0) begin errors++; $display("FAIL fetch_e0_rd got %b want 0", mem_rd); end
        @(negedge clk);
        checks++;
        if ({mem_rd, mem_wr, mem_a} !== {2'b10, 32'd2}) begin
            errors++; $display("FAIL fetch_access got rd=%b wr=%b a=%h want rd=1 wr=0 a=2", mem_rd, mem_wr, mem_a);
        end
        @(negedge clk);
        checks++;
        if ({f_ack, d_ack, err, rdata} !== {3'b100, 32'h8680_4002}) begin
            errors++; $display("FAIL fetch_ack got f=%b d=%b e=%b r=%h want 1 0 0 86804002", f_ack, d_ack, err, rdata);
        end
        @(negedge clk);
        checks++;
        if ({f_ack, mem_rd} !== 2'b00) begin errors++; $display("FAIL fetch_pulse got %b want 00", {f_ack, mem_rd}); end
    endtask

    task automatic test_round_robin();
        int order [$];
        logic [31:0] data [$];
        apply_reset(); fixed_lat = 0;
        // round 0: tie right after reset; round 1: lone F first; round 2: tie again with last grant F.
        for (int r = 0; r < 3; r++) begin
            order.delete(); data.delete();
            @(negedge clk);
            f_req = 1; f_addr = 32'h20 + r;
            d_req = (r != 1); d_wr = 0; d_addr = 32'd5;
            @(negedge clk); f_req = 0; d_req = 0;
            for (int c = 0; c < 12; c++) begin
                if (f_ack && d_ack) begin order.push_back(9); data.push_back(rdata); end
                else if (f_ack)     begin order.push_back(0); data.push_back(rdata); end
                else if (d_ack)     begin order.push_back(1); data.push_back(rdata); end
                @(negedge clk);
            end
            if (r == 0 || r == 2) begin
                checks++;
                if (order.size() != 2) begin
                    errors++; $display("FAIL rr%0d_count got %0d want 2", r, order.size());
                end else begin
                    checks++;
                    if (order[0] != ((r == 0) ? 0 : 1) || order[1] != ((r == 0) ? 1 : 0)) begin
                        errors++; $display("FAIL rr%0d_order got %0d,%0d want %0d,%0d", r, order[0], order[1],
                                           (r == 0) ? 0 : 1, (r == 0) ? 1 : 0);
                    end
                    checks++;
                    if (data[(r == 0) ? 1 : 0] !== init_word(5) || data[(r == 0) ? 0 : 1] !== init_word(32 + r)) begin
                        errors++; $display("FAIL rr%0d_data got %h,%h", r, data[0], data[1]);
                    end
                end
            end else begin
                checks++;
                if (order.size() != 1 || order[0] != 0) begin
                    errors++; $display("FAIL rr_single got %0d acks want one F", order.size());
                end
            end
        end
    endtask

    task automatic test_write();
        apply_reset(); fixed_lat = 0;
        @(negedge clk); d_req = 1; d_wr = 1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk); d_req = 0; d_wr = 0; d_wdata = 0;
        @(negedge clk);
        checks++;
        if ({mem_wr, mem_rd, mem_a, mem_b} !== {2'b10, 32'h10, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL write_access got wr=%b rd=%b a=%h b=%h want 1 0 10 deadbeef", mem_wr, mem_rd, mem_a, mem_b);
        end
        @(negedge clk);
        checks++;
        if ({d_ack, f_ack, err, rdata} !== {3'b100, 32'h0}) begin
            errors++; $display("FAIL write_ack got d=%b f=%b e=%b r=%h want 1 0 0 0", d_ack, f_ack, err, rdata);
        end
    endtask

    task automatic test_timeout();
        int lats [4]  = '{1000, TO - 1, TO, 0};
        int wcnt [4]  = '{TO, TO, TO, 1};
        bit werr [4]  = '{1, 0, 1, 0};
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            int  cyc;
            bit  seen, got_err;
            logic [31:0] got_data;
            fixed_lat = lats[k]; cyc = 0; seen = 0; got_err = 0; got_data = 0;
            @(negedge clk); f_req = 1; f_addr = 32'd3;
            @(negedge clk); f_req = 0;
            for (int c = 0; c < 40 && !seen; c++) begin
                @(negedge clk);
                if (mem_rd) cyc++;
                if (f_ack) begin seen = 1; got_err = err; got_data = rdata; end
            end
            checks++;
            if (!seen) begin
                errors++; $display("FAIL timeout%0d_noack got none want FAck within 40 cycles", k);
            end else begin
                checks++;
                if (cyc != wcnt[k]) begin
                    errors++; $display("FAIL timeout%0d_cycles got %0d want %0d", k, cyc, wcnt[k]);
                end
                checks++;
                if (got_err !== werr[k] || got_data !== (werr[k] ? 32'h0 : init_word(3))) begin
                    errors++; $display("FAIL timeout%0d_result got e=%b r=%h want e=%b", k, got_err, got_data, werr[k]);
                end
            end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_ignore_and_rearm();
        logic [31:0] data [$];
        logic [31:0] first_a;
        bit          a_seen;
        apply_reset(); fixed_lat = 3; a_seen = 0; first_a = 0;
        @(negedge clk); f_req = 1; f_addr = 32'd2;
        @(negedge clk); f_req = 1; f_addr = 32'd7;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            f_req = 0;
            if (mem_rd && !a_seen) begin a_seen = 1; first_a = mem_a; end
            if (f_ack) begin
                data.push_back(rdata);
                if (data.size() == 1) begin f_req = 1; f_addr = 32'd9; end
            end
        end
        checks++;
        if (first_a !== 32'd2) begin errors++; $display("FAIL ignore_addr got %h want 2", first_a); end
        checks++;
        if (data.size() != 2) begin
            errors++; $display("FAIL ignore_count got %0d want 2", data.size());
        end else begin
            checks++;
            if (data[0] !== init_word(2) || data[1] !== init_word(9)) begin
                errors++; $display("FAIL ignore_data got %h,%h want %h,%h", data[0], data[1], init_word(2), init_word(9));
            end
        end
    endtask

    task automatic test_reset_mid();
        int activity;
        apply_reset(); fixed_lat = 1000; activity = 0;
        @(negedge clk); f_req = 1; f_addr = 32'h33; d_req = 1; d_wr = 1; d_addr = 32'h44; d_wdata = 32'h1234;
        @(negedge clk); f_req = 0; d_req = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (!(mem_rd || mem_wr)) begin errors++; $display("FAIL midreset_pre got rd=%b wr=%b want access", mem_rd, mem_wr); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({mem_rd, mem_wr, mem_a, mem_b} !== 66'h0) begin
            errors++; $display("FAIL midreset_strobes got rd=%b wr=%b a=%h b=%h want 0", mem_rd, mem_wr, mem_a, mem_b);
        end
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (f_ack || d_ack || mem_rd || mem_wr) activity++;
        end
        checks++;
        if (activity != 0) begin errors++; $display("FAIL midreset_after got %0d busy cycles want 0", activity); end
    endtask

    task automatic test_random();
        apply_reset(); fixed_lat = -1;
        for (int c = 0; c < 900; c++) begin
            @(negedge clk);
            checks++;
            if ({mem_rd, mem_wr, mem_a, mem_b} !== {e_rd, e_wr, e_a, e_b}) begin
                errors++; $display("FAIL rand_mem c=%0d got rd=%b wr=%b a=%h b=%h want %b %b %h %h",
                                   c, mem_rd, mem_wr, mem_a, mem_b, e_rd, e_wr, e_a, e_b);
            end
            checks++;
            if ({f_ack, d_ack} !== {e_fack, e_dack}) begin
                errors++; $display("FAIL rand_ack c=%0d got f=%b d=%b want f=%b d=%b", c, f_ack, d_ack, e_fack, e_dack);
            end
            if (e_fack || e_dack) begin
                checks++;
                if ({err, rdata} !== {e_err, e_rdata}) begin
                    errors++; $display("FAIL rand_data c=%0d got e=%b r=%h want e=%b r=%h", c, err, rdata, e_err, e_rdata);
                end
            end
            f_req   = (c < 800) && ($urandom_range(0, 3) == 0);
            f_addr  = $urandom;
            d_req   = (c < 800) && ($urandom_range(0, 3) == 0);
            d_wr    = $urandom_range(0, 1) == 1;
            d_addr  = {24'h0, 8'($urandom_range(0, 15))};
            d_wdata = $urandom;
        end
    endtask

    initial begin
        rst = 1'b0; fixed_lat = 0;
        f_req = 0; d_req = 0; d_wr = 0; f_addr = 0; d_addr = 0; d_wdata = 0;
        test_reset();
        test_fetch();
        test_round_robin();
        test_write();
        test_timeout();
        test_ignore_and_rearm();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
